// File: rtl/shadow_write_buffer.sv
// Shadow write buffer: queues CPU writes to shadowed bank 00/01 video regions
// and replays them into E0/E1 slow RAM, one write per slow-RAM slot.
module shadow_write_buffer #(
  parameter int DEPTH    = 4,
  parameter int SLOW_DIV = 14
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        fast_clk,
  input  logic [7:0]  bank,
  input  logic [15:0] addr,
  input  logic [7:0]  dout,
  input  logic        we,
  input  logic        IO,
  input  logic [7:0]  shadow,
  output logic [16:0] sram_addr,
  output logic [7:0]  sram_data,
  output logic        sram_we,
  output logic        cpu_stall,
  output logic [4:0]  level,
  output logic        overflow
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = (SLOW_DIV > 1) ? $clog2(SLOW_DIV) : 1;
  localparam logic [4:0] FULL = 5'(DEPTH);

  typedef struct packed {
    logic        hi;
    logic [15:0] a;
    logic [7:0]  d;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [PW-1:0] wp, rp;
  logic [CW-1:0] cnt;
  logic [4:0]    level_nxt;
  logic          in_main, in_b01, in_shr, match, cap, full, slot, push, pop;

  // Bank 01 gates the four classic regions with shadow[4]; super-hires is separate.
  always_comb begin
    in_main = ((addr[15:10] == 6'b000001) & ~shadow[0]) |
              ((addr[15:10] == 6'b000010) & ~shadow[5]) |
              ((addr[15:13] == 3'b001)    & ~shadow[1]) |
              ((addr[15:13] == 3'b010)    & ~shadow[2]);
    in_shr  = (addr >= 16'h2000) && (addr <= 16'h9FFF) && !shadow[3];
    in_b01  = (in_main & ~shadow[4]) | in_shr;
    match   = ~IO & (((bank == 8'h00) & in_main) | ((bank == 8'h01) & in_b01));
  end

  assign cap  = fast_clk & we & match;
  assign full = (level == FULL);
  assign slot = (cnt == CW'(SLOW_DIV - 1));
  assign pop  = slot & (level != 5'd0);
  assign push = cap & ~full;

  always_comb begin
    level_nxt = level;
    if (push & ~pop)      level_nxt = level + 5'd1;
    else if (pop & ~push) level_nxt = level - 5'd1;
  end

  always_ff @(posedge clk_sys) begin
    if (push) mem[wp] <= '{hi: bank[0], a: addr, d: dout};
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      wp        <= '0;
      rp        <= '0;
      level     <= '0;
      cpu_stall <= 1'b0;
      overflow  <= 1'b0;
      sram_we   <= 1'b0;
      sram_addr <= '0;
      sram_data <= '0;
    end else begin
      cnt <= slot ? '0 : cnt + CW'(1);
      if (push) wp <= wp + PW'(1);
      if (pop) begin
        rp        <= rp + PW'(1);
        sram_addr <= {mem[rp].hi, mem[rp].a};
        sram_data <= mem[rp].d;
      end
      sram_we   <= pop;
      level     <= level_nxt;
      cpu_stall <= (level_nxt == FULL);
      overflow  <= overflow | (cap & full);
    end
  end

endmodule

// File: tb/tb_shadow_write_buffer.sv
// Bench for shadow_write_buffer: queue-based reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_shadow_write_buffer;
  localparam int DEPTH = 4;
  localparam int SD    = 14;

  logic        clk_sys, reset, fast_clk, we, io;
  logic [7:0]  bank, dout, shadow;
  logic [15:0] addr;
  logic [16:0] sram_addr;
  logic [7:0]  sram_data;
  logic        sram_we, cpu_stall, overflow;
  logic [4:0]  level;

  shadow_write_buffer #(.DEPTH(DEPTH), .SLOW_DIV(SD)) dut (
    .clk_sys(clk_sys), .reset(reset), .fast_clk(fast_clk), .bank(bank),
    .addr(addr), .dout(dout), .we(we), .IO(io), .shadow(shadow),
    .sram_addr(sram_addr), .sram_data(sram_data), .sram_we(sram_we),
    .cpu_stall(cpu_stall), .level(level), .overflow(overflow)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  int checks = 0, failures = 0;
  bit run = 0;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  function automatic bit m_match(input logic [7:0] b, input logic [15:0] a,
                                 input logic i, input logic [7:0] sh);
    bit main_r;
    bit shr;
    if (i || b > 8'h01) return 0;
    main_r = (a >= 16'h0400 && a <= 16'h07FF && !sh[0]) ||
             (a >= 16'h0800 && a <= 16'h0BFF && !sh[5]) ||
             (a >= 16'h2000 && a <= 16'h3FFF && !sh[1]) ||
             (a >= 16'h4000 && a <= 16'h5FFF && !sh[2]);
    if (b == 8'h00) return main_r;
    shr = (a >= 16'h2000 && a <= 16'h9FFF && !sh[3]);
    return (main_r && !sh[4]) || shr;
  endfunction

  // Reference model: cycle count since reset, a queue, and last-drain registers.
  logic [24:0] mq[$];
  int          cyc;
  bit          m_ovf, m_we;
  logic [16:0] m_addr;
  logic [7:0]  m_data;

  always @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      mq.delete(); m_ovf = 0; m_we = 0; m_addr = '0; m_data = '0; cyc = 0;
    end else begin
      int pre;
      bit c;
      logic [24:0] e;
      pre = mq.size();
      c = fast_clk && we && m_match(bank, addr, io, shadow);
      m_we = 0;
      if ((cyc % SD) == SD - 1 && pre > 0) begin
        e = mq.pop_front();
        m_we = 1; m_addr = e[24:8]; m_data = e[7:0];
      end
      if (c) begin
        if (pre == DEPTH) m_ovf = 1;
        else mq.push_back({bank[0], addr, dout});
      end
      cyc++;
    end
  end

  always @(negedge clk_sys) begin
    if (run && !reset) begin
      chk("cyc_sram_we", sram_we, m_we);
      chk("cyc_sram_addr", sram_addr, m_addr);
      chk("cyc_sram_data", sram_data, m_data);
      chk("cyc_level", level, mq.size());
      chk("cyc_cpu_stall", cpu_stall, mq.size() == DEPTH);
      chk("cyc_overflow", overflow, m_ovf);
    end
  end

  task automatic wr(input logic [7:0] b, input logic [15:0] a, input logic [7:0] d,
                    input logic w, input logic i);
    bank = b; addr = a; dout = d; we = w; io = i; fast_clk = 1'b1;
    @(posedge clk_sys); #1;
    fast_clk = 1'b0; we = 1'b0; io = 1'b0;
  endtask

  // Returns once the next edge has pre-edge phase p.
  task automatic wait_phase(input int p);
    for (int n = 0; n < 2 * SD; n++) begin
      if ((cyc % SD) == p) return;
      @(posedge clk_sys); #1;
    end
    chk("phase_timeout", 0, 1);
  endtask

  task automatic wait_pulse(output logic [16:0] a, output logic [7:0] d, output int c);
    int n;
    n = 0;
    do begin
      @(negedge clk_sys);
      n++;
    end while (!sram_we && n < 3 * SD);
    chk("pulse_seen", sram_we, 1);
    a = sram_addr; d = sram_data; c = cyc;
  endtask

  logic [16:0] pa;
  logic [7:0]  pd;
  int          pc, prev, npulse;

  initial begin
    reset = 1; fast_clk = 0; we = 0; io = 0; bank = 0; addr = 0; dout = 0; shadow = 0;
    repeat (3) @(posedge clk_sys);
    #1;
    chk("rst_level", level, 0);
    chk("rst_sram_we", sram_we, 0);
    chk("rst_stall", cpu_stall, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_sram_addr", sram_addr, 0);
    reset = 0; run = 1;

    // Ignored accesses: we=0, IO=1, bank E1
    wr(8'h00, 16'h0400, 8'h77, 1'b0, 1'b0);
    wr(8'h00, 16'h0400, 8'h78, 1'b1, 1'b1);
    wr(8'hE1, 16'h0400, 8'h79, 1'b1, 1'b0);
    chk("ign_level", level, 0);

    // Basic capture and replay
    wr(8'h00, 16'h0400, 8'h5A, 1'b1, 1'b0);
    chk("t1_level", level, 1);
    wait_pulse(pa, pd, pc);
    chk("t1_addr", pa, 17'h00400);
    chk("t1_data", pd, 8'h5A);

    // Bank 01 gating
    shadow = 8'h18;
    wr(8'h01, 16'h2000, 8'h11, 1'b1, 1'b0);
    chk("t2_s18_level", level, 0);
    shadow = 8'h0A;
    wr(8'h01, 16'h2000, 8'h11, 1'b1, 1'b0);
    chk("t2_s0a_level", level, 0);
    shadow = 8'h10;
    wr(8'h01, 16'h8000, 8'h22, 1'b1, 1'b0);
    wait_pulse(pa, pd, pc);
    chk("t2_addr", pa, 17'h18000);
    chk("t2_data", pd, 8'h22);
    wr(8'h01, 16'h2000, 8'h33, 1'b1, 1'b0);
    wait_pulse(pa, pd, pc);
    chk("t2_shr_addr", pa, 17'h12000);

    // Push coincident with a drain at level 2
    shadow = 8'h00;
    wait_phase(0);
    wr(8'h00, 16'h0401, 8'h41, 1'b1, 1'b0);
    wr(8'h00, 16'h0402, 8'h42, 1'b1, 1'b0);
    chk("t4_pre_level", level, 2);
    wait_phase(SD - 1);
    wr(8'h00, 16'h0403, 8'h43, 1'b1, 1'b0);
    chk("t4_level", level, 2);
    for (int k = 0; k < 3; k++) begin
      wait_pulse(pa, pd, pc);
      chk("t4_order", pd, 8'h41 + k);
    end

    // Overflow: five writes inside one slot
    wait_phase(0);
    for (int k = 0; k < 4; k++) wr(8'h00, 16'h0800 + 16'(k), 8'hA0 + 8'(k), 1'b1, 1'b0);
    chk("t3_stall", cpu_stall, 1);
    chk("t3_ovf_before", overflow, 0);
    wr(8'h00, 16'h0804, 8'hA4, 1'b1, 1'b0);
    chk("t3_level", level, 4);
    chk("t3_overflow", overflow, 1);
    prev = 0;
    for (int k = 0; k < 4; k++) begin
      wait_pulse(pa, pd, pc);
      chk("t3_data", pd, 8'hA0 + k);
      chk("t3_addr", pa, 17'h00800 + k);
      if (k == 0) chk("t3_stall_release", cpu_stall, 0);
      else chk("t3_spacing", pc - prev, SD);
      prev = pc;
    end

    // Reset mid-slot with three queued entries
    wait_phase(0);
    for (int k = 0; k < 3; k++) wr(8'h00, 16'h0410, 8'hC0 + 8'(k), 1'b1, 1'b0);
    repeat (2) @(posedge clk_sys);
    #1;
    chk("t5_pre_level", level, 3);
    reset = 1;
    #1;
    chk("t5_level", level, 0);
    chk("t5_sram_we", sram_we, 0);
    chk("t5_overflow", overflow, 0);
    chk("t5_stall", cpu_stall, 0);
    @(posedge clk_sys); #1;
    reset = 0;
    npulse = 0;
    for (int n = 0; n < 3 * SD; n++) begin
      @(negedge clk_sys);
      if (sram_we) npulse++;
    end
    chk("t5_no_pulses", npulse, 0);

    run = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
